// File: rtl/uart_serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_serial_pkg
// Description : Shared types, oversampling constants and frame helpers for the
//               UART serial engine.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_serial_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // cfg encoding 3 is treated as no parity
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return EVEN;
            2'd2:    return ODD;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] nbits);
        return 8'hFF >> (2'd3 - nbits);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] nbits,
                                        input parity_e    par);
        logic p;
        p = ^(data & data_mask(nbits));
        return (par == ODD) ? ~p : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_serial_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_serial_tick
// Description : Restartable 16x prescaler; tick every div+1 clocks, divisor
//               captured on restart.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_serial_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
            r_div <= '0;
        end else if (restart_i) begin
            r_cnt <= '0;
            r_div <= div_i;
        end else if (r_cnt == r_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign tick_o = !restart_i && (r_cnt == r_div);

endmodule
`default_nettype wire

// File: rtl/uart_serial_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_serial_engine
// Description : Full-duplex UART with runtime frame format (5-8 data bits,
//               none/even/odd parity, 1/2 stop bits) and a one-entry RX hold.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_serial_engine #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_nbits_i,
    input  logic [1:0]       cfg_parity_i,
    input  logic             cfg_stop2_i,
    input  logic             tx_valid_i,
    input  logic [7:0]       tx_data_i,
    output logic             tx_ready_o,
    output logic             stx_o,
    input  logic             srx_i,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_perr_o,
    output logic             rx_ferr_o,
    output logic             rx_overrun_o
);

    import uart_serial_pkg::*;

    localparam logic [3:0] LAST_TICK   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMPLE_TICK = 4'(MID_TICK - 1);

    // ------------------------------------------------------------------ TX
    tx_state_e  r_tx_state;
    logic       r_stx;
    logic [7:0] r_tx_shift;
    logic [2:0] r_tx_bitcnt;
    logic [3:0] r_tx_tick_cnt;
    logic [1:0] r_tx_nbits;
    parity_e    r_tx_par;
    logic       r_tx_stop2;
    logic       r_tx_parbit;
    logic       r_tx_stop_cnt;
    logic       w_tx_accept;
    logic       w_tx_tick;

    assign w_tx_accept = tx_valid_i && (r_tx_state == TX_IDLE);

    uart_serial_tick #(.DIV_W(DIV_W)) u_tx_tick (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .restart_i (w_tx_accept),
        .div_i     (cfg_div_i),
        .tick_o    (w_tx_tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_state    <= TX_IDLE;
            r_stx         <= 1'b1;
            r_tx_shift    <= '0;
            r_tx_bitcnt   <= '0;
            r_tx_tick_cnt <= '0;
            r_tx_nbits    <= '0;
            r_tx_par      <= NONE;
            r_tx_stop2    <= 1'b0;
            r_tx_parbit   <= 1'b0;
            r_tx_stop_cnt <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_state    <= TX_START;
            r_stx         <= 1'b0;
            r_tx_shift    <= tx_data_i;
            r_tx_bitcnt   <= '0;
            r_tx_tick_cnt <= '0;
            r_tx_nbits    <= cfg_nbits_i;
            r_tx_par      <= decode_parity(cfg_parity_i);
            r_tx_stop2    <= cfg_stop2_i;
            r_tx_parbit   <= parity_bit(tx_data_i, cfg_nbits_i, decode_parity(cfg_parity_i));
            r_tx_stop_cnt <= 1'b0;
        end else if (r_tx_state != TX_IDLE && w_tx_tick) begin
            r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == LAST_TICK) begin
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_stx      <= r_tx_shift[0];
                    end
                    TX_DATA: begin
                        // last data index is N-1 = 4 + nbits
                        if (r_tx_bitcnt == {1'b1, r_tx_nbits}) begin
                            if (r_tx_par != NONE) begin
                                r_tx_state <= TX_PARITY;
                                r_stx      <= r_tx_parbit;
                            end else begin
                                r_tx_state <= TX_STOP;
                                r_stx      <= 1'b1;
                            end
                        end else begin
                            r_tx_shift  <= r_tx_shift >> 1;
                            r_stx       <= r_tx_shift[1];
                            r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
                        end
                    end
                    TX_PARITY: begin
                        r_tx_state <= TX_STOP;
                        r_stx      <= 1'b1;
                    end
                    TX_STOP: begin
                        if (r_tx_stop2 && !r_tx_stop_cnt) begin
                            r_tx_stop_cnt <= 1'b1;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign tx_ready_o = (r_tx_state == TX_IDLE);
    assign stx_o      = r_stx;

    // ------------------------------------------------------------------ RX
    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e  r_rx_state;
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_bitcnt;
    logic [3:0] r_rx_tick_cnt;
    logic [1:0] r_rx_nbits;
    parity_e    r_rx_par;
    logic       r_rx_perr_acc;
    logic       r_rx_wait_high;
    logic       w_rx;
    logic       w_rx_tick;
    logic       w_rx_start;
    logic       w_rx_active_tick;
    logic       w_rx_sample;
    logic       w_rx_bit_end;
    logic       w_rx_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], srx_i};
        end
    end

    assign w_rx             = r_sync[SYNC_STAGES-1];
    assign w_rx_start       = (r_rx_state == RX_IDLE) && !w_rx && !r_rx_wait_high;
    assign w_rx_active_tick = (r_rx_state != RX_IDLE) && w_rx_tick;
    assign w_rx_sample      = w_rx_active_tick && (r_rx_tick_cnt == SAMPLE_TICK);
    assign w_rx_bit_end     = w_rx_active_tick && (r_rx_tick_cnt == LAST_TICK);
    assign w_rx_done        = (r_rx_state == RX_STOP) && w_rx_sample;

    uart_serial_tick #(.DIV_W(DIV_W)) u_rx_tick (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .restart_i (w_rx_start),
        .div_i     (cfg_div_i),
        .tick_o    (w_rx_tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_state     <= RX_IDLE;
            r_rx_shift     <= '0;
            r_rx_bitcnt    <= '0;
            r_rx_tick_cnt  <= '0;
            r_rx_nbits     <= '0;
            r_rx_par       <= NONE;
            r_rx_perr_acc  <= 1'b0;
            r_rx_wait_high <= 1'b0;
        end else if (w_rx_start) begin
            r_rx_state    <= RX_START;
            r_rx_shift    <= '0;
            r_rx_bitcnt   <= '0;
            r_rx_tick_cnt <= '0;
            r_rx_nbits    <= cfg_nbits_i;
            r_rx_par      <= decode_parity(cfg_parity_i);
            r_rx_perr_acc <= 1'b0;
        end else begin
            if (r_rx_wait_high && w_rx) begin
                r_rx_wait_high <= 1'b0;
            end
            if (w_rx_active_tick) begin
                r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
                case (r_rx_state)
                    RX_START: begin
                        if (w_rx_sample && w_rx) begin
                            r_rx_state <= RX_IDLE;
                        end else if (w_rx_bit_end) begin
                            r_rx_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (w_rx_sample) begin
                            r_rx_shift[r_rx_bitcnt] <= w_rx;
                        end
                        if (w_rx_bit_end) begin
                            if (r_rx_bitcnt == {1'b1, r_rx_nbits}) begin
                                r_rx_state <= (r_rx_par != NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (w_rx_sample) begin
                            r_rx_perr_acc <= (w_rx != parity_bit(r_rx_shift, r_rx_nbits, r_rx_par));
                        end
                        if (w_rx_bit_end) begin
                            r_rx_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        // leave mid stop bit so the next start edge is never missed
                        if (w_rx_sample) begin
                            r_rx_state     <= RX_IDLE;
                            r_rx_wait_high <= !w_rx;
                        end
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------- holding register
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_rx_perr;
    logic       r_rx_ferr;
    logic       r_rx_overrun;
    logic       w_rx_pop;

    assign w_rx_pop = r_rx_valid && rx_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (w_rx_done && (!r_rx_valid || w_rx_pop)) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= r_rx_shift;
                r_rx_perr  <= r_rx_perr_acc;
                r_rx_ferr  <= !w_rx;
            end else if (w_rx_done) begin
                r_rx_overrun <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_valid_o   = r_rx_valid;
    assign rx_data_o    = r_rx_data;
    assign rx_perr_o    = r_rx_perr;
    assign rx_ferr_o    = r_rx_ferr;
    assign rx_overrun_o = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_serial_engine
// Description : Scoreboard bench for uart_serial_engine: TX frames checked
//               bit by bit, RX words checked on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_serial_engine;

    localparam int DIV_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic [1:0]       cfg_nbits_i;
    logic [1:0]       cfg_parity_i;
    logic             cfg_stop2_i;
    logic             tx_valid_i;
    logic [7:0]       tx_data_i;
    logic             tx_ready_o;
    logic             stx_o;
    logic             srx_i;
    logic             rx_valid_o;
    logic             rx_ready_i;
    logic [7:0]       rx_data_o;
    logic             rx_perr_o;
    logic             rx_ferr_o;
    logic             rx_overrun_o;

    logic r_loop;
    logic r_line;

    always #5 clk_i = ~clk_i;

    assign srx_i = r_loop ? stx_o : r_line;

    uart_serial_engine #(.DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_nbits_i  (cfg_nbits_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_stop2_i  (cfg_stop2_i),
        .tx_valid_i   (tx_valid_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .stx_o        (stx_o),
        .srx_i        (srx_i),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .rx_data_o    (rx_data_o),
        .rx_perr_o    (rx_perr_o),
        .rx_ferr_o    (rx_ferr_o),
        .rx_overrun_o (rx_overrun_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    typedef struct {
        logic [15:0] bits;
        int          n;
        int          period;
    } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];
    rx_exp_t r_mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovr = 0;
    int ovr_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_rx(input logic [7:0] d, input logic p, input logic f);
        rx_q.push_back('{data: d, perr: p, ferr: f});
    endtask

    task automatic exp_tx(input logic [15:0] bits, input int n, input int period);
        tx_q.push_back('{bits: bits, n: n, period: period});
    endtask

    task automatic send_tx(input logic [7:0] d);
        int k;
        k = 0;
        @(negedge clk_i);
        while (!tx_ready_o && k < 5000) begin
            @(negedge clk_i);
            k++;
        end
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input int period);
        for (int i = 0; i < n; i++) begin
            r_line = bits[i];
            repeat (period) @(negedge clk_i);
        end
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!(rx_q.size() == 0 && tx_q.size() == 0 && tx_ready_o) && k < bound) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: timed out after %0d clocks, rx pending %0d, tx pending %0d",
                     k, rx_q.size(), tx_q.size());
        end
        repeat (20) @(negedge clk_i);
    endtask

    // RX scoreboard: pops on every accepted word
    always @(negedge clk_i) begin
        if (rst_n_i && rx_valid_o && rx_ready_i) begin
            if (rx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected: got word %0h (perr %0b ferr %0b), expected none",
                         rx_data_o, rx_perr_o, rx_ferr_o);
            end else begin
                r_mon_e = rx_q.pop_front();
                check("rx_data", 32'(rx_data_o), 32'(r_mon_e.data));
                check("rx_perr", 32'(rx_perr_o), 32'(r_mon_e.perr));
                check("rx_ferr", 32'(rx_ferr_o), 32'(r_mon_e.ferr));
            end
        end
    end

    always @(negedge clk_i) begin
        if (rx_overrun_o) n_ovr++;
    end

    // TX monitor: samples each expected bit mid-bit and times the busy window
    initial begin : tx_mon
        logic    prev_ready;
        tx_exp_t t;
        int      low_cnt;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && prev_ready && !tx_ready_o && tx_q.size() > 0) begin
                t = tx_q.pop_front();
                low_cnt = 0;
                for (int j = 0; j < t.n * t.period + 200 && !tx_ready_o; j++) begin
                    if ((j % t.period) == (t.period / 2) && (j / t.period) < t.n)
                        check("tx_bit", 32'(stx_o), 32'(t.bits[j / t.period]));
                    low_cnt++;
                    @(negedge clk_i);
                end
                check("tx_ready_low_clocks", 32'(low_cnt), 32'(t.n * t.period));
            end
            prev_ready = tx_ready_o;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n_i      = 1'b0;
        cfg_div_i    = 16'd3;
        cfg_nbits_i  = 2'd3;
        cfg_parity_i = 2'd0;
        cfg_stop2_i  = 1'b0;
        tx_valid_i   = 1'b0;
        tx_data_i    = 8'h00;
        rx_ready_i   = 1'b1;
        r_loop       = 1'b1;
        r_line       = 1'b1;

        repeat (3) @(negedge clk_i);
        check("reset_stx",      32'(stx_o),        32'd1);
        check("reset_tx_ready", 32'(tx_ready_o),   32'd1);
        check("reset_rx_valid", 32'(rx_valid_o),   32'd0);
        check("reset_rx_data",  32'(rx_data_o),    32'd0);
        check("reset_rx_perr",  32'(rx_perr_o),    32'd0);
        check("reset_rx_ferr",  32'(rx_ferr_o),    32'd0);
        check("reset_overrun",  32'(rx_overrun_o), 32'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // 8N1 div=3, 0xA5 over loopback
        exp_tx({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 64);
        exp_rx(8'hA5, 1'b0, 1'b0);
        send_tx(8'hA5);
        wait_done(2000);

        // 7E2 div=0, 0x35: parity 0, two stop bits
        cfg_div_i    = 16'd0;
        cfg_nbits_i  = 2'd2;
        cfg_parity_i = 2'd1;
        cfg_stop2_i  = 1'b1;
        exp_tx({5'b0, 2'b11, 1'b0, 7'h35, 1'b0}, 11, 16);
        exp_rx(8'h35, 1'b0, 1'b0);
        send_tx(8'h35);
        wait_done(1000);

        // 8O1 div=1, directly driven: good parity then bad parity
        r_loop       = 1'b0;
        r_line       = 1'b1;
        cfg_div_i    = 16'd1;
        cfg_nbits_i  = 2'd3;
        cfg_parity_i = 2'd2;
        cfg_stop2_i  = 1'b0;
        @(negedge clk_i);
        exp_rx(8'h01, 1'b0, 1'b0);
        drive_bits({5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 32);
        repeat (64) @(negedge clk_i);
        exp_rx(8'h01, 1'b1, 1'b0);
        drive_bits({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 32);
        wait_done(1000);

        // 8N1 div=1: stop bit low, then a 12-bit-time break, then recovery
        cfg_parity_i = 2'd0;
        @(negedge clk_i);
        exp_rx(8'h55, 1'b0, 1'b1);
        drive_bits({6'b0, 1'b0, 8'h55, 1'b0}, 10, 32);
        r_line = 1'b1;
        repeat (64) @(negedge clk_i);
        exp_rx(8'h00, 1'b0, 1'b1);
        r_line = 1'b0;
        repeat (12 * 32) @(negedge clk_i);
        r_line = 1'b1;
        wait_done(1000);
        exp_rx(8'h3C, 1'b0, 1'b0);
        drive_bits({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 32);
        wait_done(1000);

        // div=0: 4-clock glitch must be rejected
        cfg_div_i = 16'd0;
        @(negedge clk_i);
        r_line = 1'b0;
        repeat (4) @(negedge clk_i);
        r_line = 1'b1;
        repeat (60) @(negedge clk_i);

        // back-to-back 0x11, 0x22 with the consumer stalled
        @(posedge clk_i);
        #1 rx_ready_i = 1'b0;
        ovr_base = n_ovr;
        exp_rx(8'h11, 1'b0, 1'b0);
        @(negedge clk_i);
        drive_bits({6'b0, 1'b1, 8'h11, 1'b0}, 10, 16);
        drive_bits({6'b0, 1'b1, 8'h22, 1'b0}, 10, 16);
        r_line = 1'b1;
        repeat (40) @(negedge clk_i);
        check("overrun_pulses", 32'(n_ovr - ovr_base), 32'd1);
        check("held_valid",     32'(rx_valid_o),       32'd1);
        check("held_data",      32'(rx_data_o),        32'h11);
        @(posedge clk_i);
        #1 rx_ready_i = 1'b1;
        wait_done(200);

        // reset mid TX data: line forced high, nothing reported afterwards
        r_loop       = 1'b1;
        cfg_div_i    = 16'd3;
        cfg_nbits_i  = 2'd3;
        cfg_parity_i = 2'd0;
        cfg_stop2_i  = 1'b0;
        send_tx(8'h00);
        repeat (3 * 64) @(negedge clk_i);
        check("stx_in_data",      32'(stx_o),      32'd0);
        check("tx_busy_in_data",  32'(tx_ready_o), 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_reset_stx",      32'(stx_o),      32'd1);
        check("async_reset_tx_ready", 32'(tx_ready_o), 32'd1);
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (1000) @(negedge clk_i);
        check("post_reset_tx_ready", 32'(tx_ready_o), 32'd1);
        check("post_reset_stx",      32'(stx_o),      32'd1);
        check("post_reset_rx_valid", 32'(rx_valid_o), 32'd0);

        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("total_overruns",   32'(n_ovr),       32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_serial_engine.md
# uart_serial_engine

Parametrised UART serial engine, successor to the fixed 8N1 serial BFM core. It provides a full-duplex TX/RX pair with runtime-selectable frame format: 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. Each direction has its own restartable 16x prescaler, and both directions use valid/ready handshakes. RX adds false-start rejection, parity, framing and overrun reporting. The block sits between the BFM API layer (or an SoC bus wrapper) and the UART pads.

## Interface
Parameters:
- DIV_W, 16, width of the clock-divisor input.
- SYNC_STAGES, 2, number of srx_i synchroniser flops (minimum 2).

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cfg_div_i  in  DIV_W  16x tick period is cfg_div_i+1 clocks.
- cfg_nbits_i  in  2  data bits = 5 + cfg_nbits_i.
- cfg_parity_i  in  2  0 none, 1 even, 2 odd, 3 none.
- cfg_stop2_i  in  1  1 selects two stop bits (TX only).
- tx_valid_i  in  1  TX byte offered.
- tx_data_i  in  8  TX byte; bits above N are ignored.
- tx_ready_o  out  1  TX idle; accepts a byte.
- stx_o  out  1  serial out; idles high.
- srx_i  in  1  serial in; asynchronous to clk_i.
- rx_valid_o  out  1  received word held.
- rx_ready_i  in  1  consumer accepts the held word.
- rx_data_o  out  8  received word, right-justified; bits [7:N] are 0.
- rx_perr_o  out  1  parity error for the held word.
- rx_ferr_o  out  1  framing error for the held word.
- rx_overrun_o  out  1  one-clock pulse when a completed frame is dropped.

## Operation
- Format is latched per frame: TX latches it at acceptance, RX latches it at start detect. Changes mid-frame have no effect on the frame in progress.
- Tick generator: counter restarts at 0 on frame start. It issues a one-clock tick when count == latched div, then wraps to 0. A bit lasts 16 ticks = 16*(div+1) clocks. div=0 gives a tick every clock.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - tx_ready_o=1 only in IDLE. A byte is accepted on tx_valid_i & tx_ready_o.
  - START drives 0, then DATA sends N bits LSB-first.
  - PARITY state is present only if parity is enabled. Even parity makes the total count of ones even (the bit is the XOR of the data bits); odd parity inverts it.
  - STOP drives 1 for 1 or 2 bits, then the FSM returns to IDLE.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - RX uses only the synchronised srx. A low in IDLE restarts the RX prescaler and enters START.
  - Every bit is sampled on its 8th tick.
  - A START sample of 1 is a false start: return to IDLE and report nothing.
  - DATA shifts samples in LSB-first. PARITY compares the sample against the computed parity bit. STOP samples once, and a sample of 0 sets ferr.
  - RX returns to IDLE directly after the stop sample, for resync. The second stop bit is never checked.
- RX holding register is a single entry:
  - A frame completes when its stop bit is sampled. If rx_valid_o=0 at that point, load data/perr/ferr and set rx_valid_o.
  - If rx_valid_o=1, the new frame is dropped, the held word is unchanged, and rx_overrun_o pulses.
  - rx_valid_o clears on rx_valid_o & rx_ready_i.
  - Same-cycle pop and completion: the pop wins and the new frame loads the register; no overrun.
- A break (line held low for the whole frame) is delivered as data 0x00 with ferr=1. RX then waits in IDLE for the line to return high before it can detect a new start.

## Timing
- Reset values: stx_o=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, rx_perr_o=0, rx_ferr_o=0, rx_overrun_o=0. FSMs go to IDLE and the synchroniser flops to 1.
- Assertion of rst_n_i mid-frame forces stx_o high immediately and aborts both frames with no report.
- TX:
  - stx_o falls on the clock after acceptance; tx_ready_o falls on that same edge.
  - Frame length is (1+N+P+S)*16*(div+1) clocks; tx_ready_o rises on the clock that ends the last stop bit.
  - A byte offered in that cycle starts back-to-back with no idle gap.
- RX:
  - srx edge to start detect takes SYNC_STAGES clocks.
  - rx_valid_o rises on the clock after the stop-bit sample.

## Structure
- Package uart_serial_pkg holds the parity_e enum (NONE, EVEN, ODD), the tx_state_e and rx_state_e enums, OVERSAMPLE=16, and MID_TICK=8.
- Sub-module uart_serial_tick: restartable prescaler with restart, div and tick_o. It is instantiated once for TX and once for RX.
- The engine contains the two FSMs, the synchroniser and the holding register.

## Test plan
- 8N1, div=3, send 0xA5 -> stx_o reads 0,1,0,1,0,0,1,0,1,1 with each bit 64 clocks. tx_ready_o is low for exactly 640 clocks. On loopback to srx_i, the RX side delivers rx_data_o=0xA5 with perr=0 and ferr=0.
- 7E2, div=0, send 0x35 -> 11-bit frame with parity bit 0 and two stop bits, 176 clocks. On loopback, rx_data_o=0x35.
- 8O1, drive a frame for 0x01 with parity bit 0 (correct is 0) -> no error; drive the same frame with parity bit 1 -> rx_data_o=0x01 and rx_perr_o=1.
- Drive 8N1 0x55 with the stop bit low -> rx_ferr_o=1. Hold the line low for 12 bit times -> data 0x00 with ferr=1, and no second frame until the line returns high.
- div=0: a 4-clock low glitch -> no rx_valid_o. Two back-to-back frames (0x11 then 0x22) with rx_ready_i=0 -> 0x11 is held and rx_overrun_o pulses once.
- Assert rst_n_i during the TX DATA state -> stx_o=1 immediately. After release, tx_ready_o=1 and no rx_valid_o appears.
